xbtn_ctrl: RTL and testbench



---
 rtl/xbtn_ctrl.sv | 159 +++++++++++++++
 tb/tb_xbtn_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xbtn_ctrl.sv
// xbtn_ctrl: memory-mapped push-button / switch peripheral.
// Each raw input is synchronised (2 FFs), debounced (DEBOUNCE_CYC stable
// cycles), and its rising/falling edges are latched in sticky flags.
// Register map: 0 LEVEL (RO), 1 PRESS (read-clears), 2 REL (W1C), 3 CTRL.
// Optional feature macro: BTN_IRQ_EN -- adds the CTRL mask/enable register
// and a registered interrupt; without it CTRL reads 0 and irq is tied low.
// With BTN_IRQ_EN the enable bit sits at CTRL[NB], so NB must be below DATA_W.
module xbtn_ctrl #(
  parameter int NB           = 4,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [NB-1:0]     btn,
  output logic              irq
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] A_LEVEL = 2'd0;
  localparam logic [1:0] A_PRESS = 2'd1;
  localparam logic [1:0] A_REL   = 2'd2;

  logic [NB-1:0] r_s1;
  logic [NB-1:0] r_s2;
  logic [NB-1:0] r_lvl;
  logic [NB-1:0] r_press;
  logic [NB-1:0] r_rel;
  logic [CW-1:0] r_cnt [NB];

  logic [CW-1:0] w_cnt_nxt [NB];
  logic [NB-1:0] w_toggle;
  logic [NB-1:0] w_rise;
  logic [NB-1:0] w_fall;
  logic [NB-1:0] w_w1c;
  logic          w_wr;
  logic          w_rd_press;

  // Only the low NB bits (plus the enable bit with BTN_IRQ_EN) of a write
  // carry meaning; fold the whole bus here so the rest is visibly ignored.
  logic w_unused_data;
  assign w_unused_data = ^data_in;

  // Two-stage synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      // NOTE: non-blocking so r_s2 takes the old r_s1; blocking here would
      // collapse the chain into a single flop.
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end

  // Debounce decision: count consecutive cycles the synchronised input
  // disagrees with the accepted level; toggle on the DEBOUNCE_CYC-th one.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      // NOTE: defaults first so every path assigns every output; a missing
      // else branch would otherwise infer a latch.
      w_toggle[i]  = 1'b0;
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_lvl[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_toggle[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Accepted level and per-bit stability counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl <= '0;
      // NOTE: the counter array is cleared explicitly so a reset in the
      // middle of a debounce window discards the partial count.
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_lvl <= r_lvl ^ w_toggle;
      for (int i = 0; i < NB; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign w_rise     = w_toggle & ~r_lvl;
  assign w_fall     = w_toggle &  r_lvl;
  assign w_wr       = sel & we;
  assign w_rd_press = sel & ~we & (addr == A_PRESS);
  assign w_w1c      = (w_wr && (addr == A_REL)) ? data_in[NB-1:0] : '0;

  // Sticky edge flags; a new edge in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press <= '0;
      r_rel   <= '0;
    end else begin
      r_press <= (w_rd_press ? '0 : r_press) | w_rise;
      r_rel   <= (r_rel & ~w_w1c) | w_fall;
    end
  end

`ifdef BTN_IRQ_EN
  localparam logic [1:0] A_CTRL = 2'd3;

  logic [NB-1:0] r_mask;
  logic          r_en;
  logic          r_irq;

  // Interrupt mask/enable register and the registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
      r_en   <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && (addr == A_CTRL)) begin
        r_mask <= data_in[NB-1:0];
        r_en   <= data_in[NB];
      end
      r_irq <= r_en & (|(r_press & r_mask));
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // Read mux, combinational from addr; unused upper bits read as 0.
  always_comb begin
    data_out = '0;
    case (addr)
      A_LEVEL: data_out[NB-1:0] = r_lvl;
      A_PRESS: data_out[NB-1:0] = r_press;
      A_REL:   data_out[NB-1:0] = r_rel;
      default: begin
`ifdef BTN_IRQ_EN
        data_out[NB-1:0] = r_mask;
        data_out[NB]     = r_en;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_xbtn_ctrl.sv
// Testbench for xbtn_ctrl (NB=4, DEBOUNCE_CYC=8). Directed stimulus with
// literal expectations, plus a window-based reference model compared against
// data_out and irq on every falling clock edge.
module tb_xbtn_ctrl;

  localparam int NB = 4;
  localparam int D  = 8;
  localparam int W  = 32;

  logic          clk;
  logic          rst;
  logic          sel;
  logic          we;
  logic [1:0]    addr;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic [NB-1:0] btn;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  xbtn_ctrl #(.NB(NB), .DEBOUNCE_CYC(D), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .btn      (btn),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_hist[j] holds the raw btn value sampled j+1 edges ago. The debouncer
  // sees the input two edges late, so the window that decides a toggle at
  // this edge is m_hist[1..D]: the level flips when all D of those samples
  // disagree with it.
  logic [NB-1:0] m_hist [0:D];
  logic [NB-1:0] m_lvl, m_press, m_rel, m_mask;
  logic          m_en, m_irq;
  logic          m_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v[NB-1:0] = m_lvl;
      2'd1: v[NB-1:0] = m_press;
      2'd2: v[NB-1:0] = m_rel;
      default: begin
`ifdef BTN_IRQ_EN
        v[NB-1:0] = m_mask;
        v[NB]     = m_en;
`endif
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [NB-1:0] tog, rise, fall, w1c;
    logic          all_diff;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k <= D; k++) m_hist[k] = '0;
        m_lvl = '0; m_press = '0; m_rel = '0; m_mask = '0;
        m_en = 1'b0; m_irq = 1'b0;
        m_valid = 1'b1;
      end else begin
        tog = '0;
        for (int i = 0; i < NB; i++) begin
          all_diff = 1'b1;
          for (int k = 1; k <= D; k++)
            if (m_hist[k][i] == m_lvl[i]) all_diff = 1'b0;
          tog[i] = all_diff;
        end
        rise = tog & ~m_lvl;
        fall = tog & m_lvl;
        w1c  = (sel && we && addr == 2'd2) ? data_in[NB-1:0] : '0;
`ifdef BTN_IRQ_EN
        m_irq = m_en & (|(m_press & m_mask));
        if (sel && we && addr == 2'd3) begin
          m_mask = data_in[NB-1:0];
          m_en   = data_in[NB];
        end
`endif
        m_press = ((sel && !we && addr == 2'd1) ? '0 : m_press) | rise;
        m_rel   = (m_rel & ~w1c) | fall;
        m_lvl   = m_lvl ^ tog;
        for (int k = D; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = btn;
      end
    end
  end

  // Compare process: outputs against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("mon_data_out", data_out, m_read(addr));
        check("mon_irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    check(nm, data_out, exp);
    step();
    sel = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    step();
    sel = 1'b0; we = 1'b0; data_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0; btn = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_irq", 32'(irq), 32'h0);
    rd(2'd0, 32'h0, "rst_level");
    rd(2'd1, 32'h0, "rst_press");
    rd(2'd2, 32'h0, "rst_rel");
    rd(2'd3, 32'h0, "rst_ctrl");

    // btn[1] rises: LEVEL changes exactly 2+D = 10 edges later
    addr = 2'd0;
    btn[1] = 1'b1;
    repeat (9) step();
    check("lvl_edge9", data_out, 32'h0);
    step();
    check("lvl_edge10", data_out, 32'h2);
    rd(2'd1, 32'h2, "press_first");
    rd(2'd1, 32'h0, "press_second");

    // btn[0] glitches shorter than D never get accepted
    repeat (3) begin
      btn[0] = 1'b1; repeat (5) step();
      btn[0] = 1'b0; repeat (5) step();
    end
    repeat (12) step();
    rd(2'd0, 32'h2, "glitch_level");
    rd(2'd1, 32'h0, "glitch_press");

    // btn[2] press/release, REL W1C
    btn[2] = 1'b1; repeat (12) step();
    btn[2] = 1'b0; repeat (12) step();
    rd(2'd2, 32'h4, "rel_set");
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h0, "rel_w1c");
    rd(2'd1, 32'h4, "press_btn2");
    // Second release lands on the W1C cycle: set wins
    btn[2] = 1'b1; repeat (12) step();
    btn[2] = 1'b0; repeat (9) step();
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h4, "rel_set_wins");

    // PRESS read-clear in the same cycle lvl[3] rises (press[2] pending)
    btn[3] = 1'b1; repeat (9) step();
    rd(2'd1, 32'h4, "press_rdclr_old");
    rd(2'd1, 32'h8, "press_set_wins");
    rd(2'd1, 32'h0, "press_cleared");

    // Reset mid-debounce with buttons held through reset release
    addr = 2'd0;
    btn[0] = 1'b1; repeat (5) step();
    rst = 1'b1; repeat (2) step();
    check("rst_mid_level", data_out, 32'h0);
    rst = 1'b0;
    repeat (9) step();
    check("held_edge9", data_out, 32'h0);
    step();
    check("held_edge10", data_out, 32'hB);
    rd(2'd1, 32'hB, "press_after_rst");
    rd(2'd2, 32'h0, "rel_after_rst");

`ifdef BTN_IRQ_EN
    btn[0] = 1'b0; repeat (12) step();
    wr(2'd2, 32'h1);
    wr(2'd3, 32'h11);
    rd(2'd3, 32'h11, "ctrl_rw");
    btn[0] = 1'b1; repeat (10) step();
    check("irq_not_yet", 32'(irq), 32'h0);
    step();
    check("irq_set", 32'(irq), 32'h1);
    rd(2'd1, 32'h1, "press_irq");
    check("irq_hold", 32'(irq), 32'h1);
    step();
    check("irq_clear", 32'(irq), 32'h0);
    btn[1] = 1'b0; repeat (12) step();
    btn[1] = 1'b1; repeat (12) step();
    check("irq_masked", 32'(irq), 32'h0);
    rd(2'd1, 32'h2, "press_masked");
`else
    wr(2'd3, 32'h1F);
    rd(2'd3, 32'h0, "ctrl_absent");
    check("irq_absent", 32'(irq), 32'h0);
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
